// File: rtl/usb_fifo_responder.sv
// Target-side responder for the 8-bit USB bridge parallel FIFO bus: synchronizes host strobes,
// buffers host->fabric bytes in an RX FIFO and fabric->host bytes in a TX FIFO.
module usb_fifo_responder #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     FPGA_SYSTEM_CLK,
    input  logic                     FPGA_SYS_RESET,
    input  logic [7:0]               usb_data_in,
    output logic [7:0]               usb_data_out,
    output logic                     usb_data_oe,
    input  logic                     usb_wrn,
    input  logic                     usb_rdn,
    input  logic                     usb_oen,
    output logic                     usb_full,
    output logic                     usb_empty,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic [$clog2(DEPTH):0]   tx_level,
    input  logic                     clr_flags,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     ONE_LVL  = (AW+1)'(1);

    logic [SYNC_STAGES-1:0] wrn_sync_q, rdn_sync_q, oen_sync_q, live_q;
    logic [7:0]             data_pipe_q [SYNC_STAGES];
    logic                   wrn_prev_q, rdn_prev_q;
    logic                   wrn_armed_q, wrn_armed_d;
    logic                   rdn_armed_q, rdn_armed_d;
    logic                   oe_q;

    logic [7:0]             rx_mem [DEPTH];
    logic [7:0]             tx_mem [DEPTH];
    logic [AW:0]            rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]            tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   ovf_q, ovf_d, udf_q, udf_d;

    logic wrn_s, rdn_s, live;
    logic wrn_fall, rdn_fall;
    logic rx_push, rx_pop, tx_push, host_pop;
    logic ovf_evt, udf_evt;

    assign wrn_s = wrn_sync_q[SYNC_STAGES-1];
    assign rdn_s = rdn_sync_q[SYNC_STAGES-1];
    assign live  = live_q[SYNC_STAGES-1];

    assign rx_level     = rx_wr_q - rx_rd_q;
    assign tx_level     = tx_wr_q - tx_rd_q;
    assign rx_valid     = (rx_level != '0);
    assign rx_data      = rx_mem[rx_rd_q[AW-1:0]];
    assign tx_ready     = (tx_level != FULL_LVL);
    assign usb_full     = (rx_level == FULL_LVL);
    assign usb_empty    = (tx_level == '0);
    assign usb_data_out = data_out_q;
    assign usb_data_oe  = oe_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Arming only counts synced-high values that were genuinely sampled from the pin, not
    // the reset-idle contents of the chain, so a strobe held low over reset never fires.
    always_comb begin
        wrn_armed_d = wrn_armed_q | (live & wrn_s);
        rdn_armed_d = rdn_armed_q | (live & rdn_s);
        wrn_fall    = wrn_armed_q & wrn_prev_q & ~wrn_s;
        rdn_fall    = rdn_armed_q & rdn_prev_q & ~rdn_s;

        rx_pop      = rx_valid & rx_ready;
        rx_push     = wrn_fall & (~usb_full | rx_pop);
        ovf_evt     = wrn_fall & usb_full & ~rx_pop;
        host_pop    = rdn_fall & ~usb_empty;
        udf_evt     = rdn_fall & usb_empty;
        tx_push     = tx_valid & (tx_ready | host_pop);

        rx_wr_d     = rx_push  ? rx_wr_q + ONE_LVL : rx_wr_q;
        rx_rd_d     = rx_pop   ? rx_rd_q + ONE_LVL : rx_rd_q;
        tx_wr_d     = tx_push  ? tx_wr_q + ONE_LVL : tx_wr_q;
        tx_rd_d     = host_pop ? tx_rd_q + ONE_LVL : tx_rd_q;

        data_out_d  = usb_empty ? data_out_q : tx_mem[tx_rd_q[AW-1:0]];

        ovf_d       = ovf_evt | (ovf_q & ~clr_flags);
        udf_d       = udf_evt | (udf_q & ~clr_flags);
    end

    always_ff @(posedge FPGA_SYSTEM_CLK or posedge FPGA_SYS_RESET) begin
        if (FPGA_SYS_RESET) begin
            wrn_sync_q  <= '1;
            rdn_sync_q  <= '1;
            oen_sync_q  <= '1;
            live_q      <= '0;
            wrn_prev_q  <= 1'b1;
            rdn_prev_q  <= 1'b1;
            wrn_armed_q <= 1'b0;
            rdn_armed_q <= 1'b0;
            oe_q        <= 1'b0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            data_out_q  <= 8'h00;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wrn_sync_q  <= {wrn_sync_q[SYNC_STAGES-2:0], usb_wrn};
            rdn_sync_q  <= {rdn_sync_q[SYNC_STAGES-2:0], usb_rdn};
            oen_sync_q  <= {oen_sync_q[SYNC_STAGES-2:0], usb_oen};
            live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
            wrn_prev_q  <= wrn_s;
            rdn_prev_q  <= rdn_s;
            wrn_armed_q <= wrn_armed_d;
            rdn_armed_q <= rdn_armed_d;
            oe_q        <= ~oen_sync_q[SYNC_STAGES-1];
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            data_out_q  <= data_out_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Data path storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge FPGA_SYSTEM_CLK) begin
        data_pipe_q[0] <= usb_data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_pipe_q[i] <= data_pipe_q[i-1];
        end
        if (rx_push) begin
            rx_mem[rx_wr_q[AW-1:0]] <= data_pipe_q[SYNC_STAGES-1];
        end
        if (tx_push) begin
            tx_mem[tx_wr_q[AW-1:0]] <= tx_data;
        end
    end

endmodule

// File: tb/tb_usb_fifo_responder.sv
// Directed bench for usb_fifo_responder: host strobe timing, FIFO fill/drain, flags and reset corner cases.
module tb_usb_fifo_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] usb_data_in, usb_data_out, rx_data, tx_data;
    logic       usb_data_oe, usb_wrn, usb_rdn, usb_oen, usb_full, usb_empty;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, clr_flags, overflow, underflow;
    logic [4:0] rx_level, tx_level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    usb_fifo_responder #(.DEPTH(16), .SYNC_STAGES(2)) dut (
        .FPGA_SYSTEM_CLK(clk),
        .FPGA_SYS_RESET (rst),
        .usb_data_in    (usb_data_in),
        .usb_data_out   (usb_data_out),
        .usb_data_oe    (usb_data_oe),
        .usb_wrn        (usb_wrn),
        .usb_rdn        (usb_rdn),
        .usb_oen        (usb_oen),
        .usb_full       (usb_full),
        .usb_empty      (usb_empty),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_level       (rx_level),
        .tx_level       (tx_level),
        .clr_flags      (clr_flags),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] b);
        usb_data_in = b;
        usb_wrn     = 1'b0;
        repeat (4) @(negedge clk);
        usb_wrn     = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic host_read();
        usb_rdn = 1'b0;
        repeat (4) @(negedge clk);
        usb_rdn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic fab_pop(input logic [7:0] exp, input string tag);
        chk(tag, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic fab_push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; usb_data_in = 8'h00; usb_wrn = 1'b1; usb_rdn = 1'b1; usb_oen = 1'b1;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; clr_flags = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_usb_empty", 32'(usb_empty), 1);
        chk("rst_tx_ready",  32'(tx_ready), 1);
        chk("rst_usb_full",  32'(usb_full), 0);
        chk("rst_rx_valid",  32'(rx_valid), 0);
        chk("rst_data_out",  32'(usb_data_out), 0);
        chk("rst_oe",        32'(usb_data_oe), 0);
        chk("rst_ovf",       32'(overflow), 0);
        chk("rst_udf",       32'(underflow), 0);
        chk("rst_rx_level",  32'(rx_level), 0);
        chk("rst_tx_level",  32'(tx_level), 0);

        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Host write latency: FIFO write lands on the third edge after the pin falls.
        usb_data_in = 8'hA5;
        usb_wrn     = 1'b0;
        @(negedge clk); chk("wr_lat1", 32'(rx_valid), 0);
        @(negedge clk); chk("wr_lat2", 32'(rx_valid), 0);
        @(negedge clk); chk("wr_lat3", 32'(rx_valid), 1);
        chk("wr_data",  32'(rx_data), 'hA5);
        chk("wr_level", 32'(rx_level), 1);
        @(negedge clk);
        usb_wrn = 1'b1;
        repeat (4) @(negedge clk);
        fab_pop(8'hA5, "wr_pop");
        chk("wr_drained", 32'(rx_level), 0);

        // RX fill and overflow.
        for (int i = 0; i < 16; i++) host_write(8'(i));
        chk("fill_full",  32'(usb_full), 1);
        chk("fill_level", 32'(rx_level), 16);
        chk("fill_ovf0",  32'(overflow), 0);
        host_write(8'h77);
        chk("ovf_set",    32'(overflow), 1);
        chk("ovf_level",  32'(rx_level), 16);
        for (int i = 0; i < 16; i++) fab_pop(8'(i), "drain");
        chk("drain_empty", 32'(rx_valid), 0);
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // TX read and underflow.
        fab_push(8'h11);
        fab_push(8'h22);
        chk("tx_not_empty", 32'(usb_empty), 0);
        chk("tx_level2",    32'(tx_level), 2);
        chk("tx_head11",    32'(usb_data_out), 'h11);
        host_read();
        chk("rd1_head22",   32'(usb_data_out), 'h22);
        chk("rd1_level",    32'(tx_level), 1);
        host_read();
        chk("rd2_empty",    32'(usb_empty), 1);
        chk("rd2_udf0",     32'(underflow), 0);
        host_read();
        chk("rd3_udf",      32'(underflow), 1);
        chk("rd3_hold",     32'(usb_data_out), 'h22);

        // Output enable follows OEN regardless of FIFO state.
        usb_oen = 1'b0; repeat (4) @(negedge clk);
        chk("oe_on", 32'(usb_data_oe), 1);
        usb_oen = 1'b1; repeat (4) @(negedge clk);
        chk("oe_off", 32'(usb_data_oe), 0);

        // TX full.
        for (int i = 0; i < 16; i++) fab_push(8'(8'h40 + i));
        chk("tx_full_ready", 32'(tx_ready), 0);
        chk("tx_full_level", 32'(tx_level), 16);

        // Simultaneous RX push and pop while full.
        do_reset();
        for (int i = 0; i < 16; i++) host_write(8'(8'h20 + i));
        chk("sim_full", 32'(usb_full), 1);
        usb_data_in = 8'h99;
        usb_wrn     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sim_head", 32'(rx_data), 'h20);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("sim_level", 32'(rx_level), 16);
        chk("sim_ovf",   32'(overflow), 0);
        @(negedge clk);
        usb_wrn = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 1; i < 16; i++) fab_pop(8'(8'h20 + i), "sim_drain");
        fab_pop(8'h99, "sim_last");
        chk("sim_empty", 32'(rx_level), 0);

        // Reset with WRN held low: no access until a genuine full pulse.
        usb_wrn = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_udf", 32'(underflow), 0);
        chk("rstmid_tx",  32'(tx_level), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        usb_wrn = 1'b1;
        repeat (6) @(negedge clk);
        chk("wrnlow_nowrite", 32'(rx_level), 0);
        host_write(8'h5A);
        chk("wrnlow_one",  32'(rx_level), 1);
        chk("wrnlow_data", 32'(rx_data), 'h5A);

        // Flag clear racing a new overflow.
        for (int i = 0; i < 15; i++) host_write(8'(i));
        chk("race_full", 32'(usb_full), 1);
        usb_data_in = 8'hEE;
        usb_wrn     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        chk("race_ovf_kept", 32'(overflow), 1);
        @(negedge clk);
        clr_flags = 1'b0;
        chk("race_ovf_clr", 32'(overflow), 0);
        chk("race_level",   32'(rx_level), 16);
        usb_wrn = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
